// File: rtl/instruction_decode.sv
// instruction_decode
// Decode stage that sits directly behind instruction_fetch. It splits the
// fetched word into register indices and function fields, builds the
// sign-extended immediate, classifies the instruction format and reads both
// source operands from a 32-entry register file. Everything is then
// registered into the ID/EX boundary. imm_o and optype_o also go back to
// fetch so it can compute branch and jump targets.
//
// Ports
//   clk_i          rising-edge clock
//   rst_ni         asynchronous active-low reset (clears ID/EX and the regfile)
//   stall_i        hold the ID/EX contents
//   flush_i        load a bubble into ID/EX (wins over stall_i)
//   pc_i           PC of instruction_i
//   instruction_i  fetched instruction word
//   wb_en_i        register-file write enable
//   wb_addr_i      register-file write index
//   wb_data_i      register-file write data
//   pc_o           registered PC
//   optype_o       R/I/S/B/U/UJ class
//   rs1_addr_o, rs2_addr_o, rd_addr_o   registered register indices
//   rs1_data_o, rs2_data_o              registered operands
//   imm_o          sign-extended immediate
//   funct3_o, funct7_o                  registered function fields
//   valid_o        slot holds a real instruction
//   illegal_o      opcode is not supported

package instruction_decode_pkg;
  typedef enum logic [2:0] {
    OP_R  = 3'd0,
    OP_I  = 3'd1,
    OP_S  = 3'd2,
    OP_B  = 3'd3,
    OP_U  = 3'd4,
    OP_UJ = 3'd5
  } instruction_op_type;
endpackage

module instruction_decode
  import instruction_decode_pkg::*;
#(
  parameter int DATA_WIDTH            = 32,
  parameter int PROGRAM_ADDRESS_WIDTH = 32,
  parameter int REG_COUNT             = 32,
  localparam int IDX_W                = $clog2(REG_COUNT)
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             stall_i,
  input  logic                             flush_i,
  input  logic [PROGRAM_ADDRESS_WIDTH-1:0] pc_i,
  input  logic [31:0]                      instruction_i,
  input  logic                             wb_en_i,
  input  logic [IDX_W-1:0]                 wb_addr_i,
  input  logic [DATA_WIDTH-1:0]            wb_data_i,
  output logic [PROGRAM_ADDRESS_WIDTH-1:0] pc_o,
  output instruction_op_type               optype_o,
  output logic [IDX_W-1:0]                 rs1_addr_o,
  output logic [IDX_W-1:0]                 rs2_addr_o,
  output logic [IDX_W-1:0]                 rd_addr_o,
  output logic [DATA_WIDTH-1:0]            rs1_data_o,
  output logic [DATA_WIDTH-1:0]            rs2_data_o,
  output logic [31:0]                      imm_o,
  output logic [2:0]                       funct3_o,
  output logic [6:0]                       funct7_o,
  output logic                             valid_o,
  output logic                             illegal_o
);

  logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];

  instruction_op_type opType_d;
  logic               illegal_d;
  logic [31:0]        imm_d;
  logic [IDX_W-1:0]   rs1Addr_d, rs2Addr_d, rdAddr_d;
  logic [DATA_WIDTH-1:0] rs1Data_d, rs2Data_d;

  logic [PROGRAM_ADDRESS_WIDTH-1:0] pc_q;
  instruction_op_type               optype_q;
  logic [IDX_W-1:0]                 rs1Addr_q, rs2Addr_q, rdAddr_q;
  logic [DATA_WIDTH-1:0]            rs1Data_q, rs2Data_q;
  logic [31:0]                      imm_q;
  logic [2:0]                       funct3_q;
  logic [6:0]                       funct7_q;
  logic                             valid_q, illegal_q;

  // Format classification, immediate generation and index forcing.
  // Unsupported opcodes are treated as I-format with no destination.
  always_comb begin
    opType_d  = OP_I;
    illegal_d = 1'b0;
    imm_d     = '0;
    unique case (instruction_i[6:0])
      7'b0110011:                         opType_d = OP_R;
      7'b0010011, 7'b0000011, 7'b1100111: opType_d = OP_I;
      7'b0100011:                         opType_d = OP_S;
      7'b1100011:                         opType_d = OP_B;
      7'b0110111, 7'b0010111:             opType_d = OP_U;
      7'b1101111:                         opType_d = OP_UJ;
      default:                            illegal_d = 1'b1;
    endcase

    case (opType_d)
      OP_I:    imm_d = {{20{instruction_i[31]}}, instruction_i[31:20]};
      OP_S:    imm_d = {{20{instruction_i[31]}}, instruction_i[31:25], instruction_i[11:7]};
      OP_B:    imm_d = {{19{instruction_i[31]}}, instruction_i[31], instruction_i[7],
                        instruction_i[30:25], instruction_i[11:8], 1'b0};
      OP_U:    imm_d = {instruction_i[31:12], 12'b0};
      OP_UJ:   imm_d = {{11{instruction_i[31]}}, instruction_i[31], instruction_i[19:12],
                        instruction_i[20], instruction_i[30:21], 1'b0};
      default: imm_d = '0;
    endcase

    rdAddr_d  = (opType_d == OP_S || opType_d == OP_B || illegal_d) ? '0 : instruction_i[11:7];
    rs1Addr_d = (opType_d == OP_U || opType_d == OP_UJ) ? '0 : instruction_i[19:15];
    rs2Addr_d = (opType_d == OP_I || opType_d == OP_U || opType_d == OP_UJ) ? '0
                                                                             : instruction_i[24:20];
  end

  // Operand read with write-through so a same-edge writeback is not missed.
  always_comb begin
    rs1Data_d = '0;
    rs2Data_d = '0;
    if (rs1Addr_d != '0)
      rs1Data_d = (wb_en_i && wb_addr_i == rs1Addr_d) ? wb_data_i : regs_q[rs1Addr_d];
    if (rs2Addr_d != '0)
      rs2Data_d = (wb_en_i && wb_addr_i == rs2Addr_d) ? wb_data_i : regs_q[rs2Addr_d];
  end

  // Register file; x0 is never written so it always reads back as zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < REG_COUNT; r++) regs_q[r] <= '0;
    end else if (wb_en_i && wb_addr_i != '0) begin
      regs_q[wb_addr_i] <= wb_data_i;
    end
  end

  // ID/EX boundary. While stalled, a writeback to a held source register is
  // folded into the held operand so the instruction leaves with fresh data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q <= '0; optype_q <= OP_I; rs1Addr_q <= '0; rs2Addr_q <= '0; rdAddr_q <= '0;
      rs1Data_q <= '0; rs2Data_q <= '0; imm_q <= '0; funct3_q <= '0; funct7_q <= '0;
      valid_q <= 1'b0; illegal_q <= 1'b0;
    end else if (flush_i) begin
      pc_q <= '0; optype_q <= OP_I; rs1Addr_q <= '0; rs2Addr_q <= '0; rdAddr_q <= '0;
      rs1Data_q <= '0; rs2Data_q <= '0; imm_q <= '0; funct3_q <= '0; funct7_q <= '0;
      valid_q <= 1'b0; illegal_q <= 1'b0;
    end else if (stall_i) begin
      if (wb_en_i && rs1Addr_q != '0 && wb_addr_i == rs1Addr_q) rs1Data_q <= wb_data_i;
      if (wb_en_i && rs2Addr_q != '0 && wb_addr_i == rs2Addr_q) rs2Data_q <= wb_data_i;
    end else begin
      pc_q      <= pc_i;
      optype_q  <= opType_d;
      rs1Addr_q <= rs1Addr_d;
      rs2Addr_q <= rs2Addr_d;
      rdAddr_q  <= rdAddr_d;
      rs1Data_q <= rs1Data_d;
      rs2Data_q <= rs2Data_d;
      imm_q     <= imm_d;
      funct3_q  <= instruction_i[14:12];
      funct7_q  <= instruction_i[31:25];
      valid_q   <= 1'b1;
      illegal_q <= illegal_d;
    end
  end

  assign pc_o       = pc_q;
  assign optype_o   = optype_q;
  assign rs1_addr_o = rs1Addr_q;
  assign rs2_addr_o = rs2Addr_q;
  assign rd_addr_o  = rdAddr_q;
  assign rs1_data_o = rs1Data_q;
  assign rs2_data_o = rs2Data_q;
  assign imm_o      = imm_q;
  assign funct3_o   = funct3_q;
  assign funct7_o   = funct7_q;
  assign valid_o    = valid_q;
  assign illegal_o  = illegal_q;

endmodule
